// File: rtl/led_fade_buffer.sv
// led_fade_buffer
//   Per-LED colour store feeding the ws2812c driver. Each entry holds a
//   target colour (written by application logic) and a current colour
//   (what the driver sees). Every FADE_DIV clocks a walk visits each entry
//   once and moves every channel of its current colour up to STEP toward
//   the target, landing exactly on the target without overshoot.
//
// Ports
//   clk                    system clock
//   reset                  synchronous, active-high; clears every entry
//   wr_en / wr_snap        write a target; with wr_snap also force current
//   wr_addr                LED index for the write (>= NUM_LEDS ignored)
//   wr_red/green/blue      written colour
//   address                LED index requested by the driver
//   red/green/blue_out     current colour of address, one cycle later
//   busy                   high while the fade walk is running
//   settled                high when every current colour equals its target
module led_fade_buffer #(
    parameter int NUM_LEDS = 8,
    parameter int FADE_DIV = 48000,
    parameter int STEP     = 1,
    parameter int AW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic          wr_snap,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_red,
    input  logic [7:0]    wr_green,
    input  logic [7:0]    wr_blue,
    input  logic [AW-1:0] address,
    output logic [7:0]    red_out,
    output logic [7:0]    green_out,
    output logic [7:0]    blue_out,
    output logic          busy,
    output logic          settled
);

    localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int CW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LEDS - 1);
    localparam logic [CW-1:0] TICK_CNT = CW'(FADE_DIV - 1);
    localparam logic [7:0]    STEP_V   = 8'(STEP);

    typedef enum logic {IDLE = 1'b0, WALK = 1'b1} state_t;

    // Colour entries packed as {red, green, blue}.
    logic [23:0] tgt_mem [NUM_LEDS];
    logic [23:0] cur_mem [NUM_LEDS];

    state_t        state_q, state_d;
    logic [IW-1:0] index_q, index_d;
    logic [CW-1:0] cnt_q;
    logic          tick;
    logic          differs_q;

    logic          wr_ok, rd_ok;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [23:0]   wr_data;
    logic          step_en, step_diff, last_walk;
    logic [23:0]   cur_sel, tgt_sel, step_val;

    // Move one channel toward its target by at most STEP. The distance is
    // compared before adding/subtracting, so the result can never wrap past
    // 0 or 255 and always lands exactly on the target.
    function automatic logic [7:0] step_ch(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] r;
        r = cur;
        if (cur < tgt) begin
            if ((tgt - cur) <= STEP_V) r = tgt;
            else                       r = cur + STEP_V;
        end else if (cur > tgt) begin
            if ((cur - tgt) <= STEP_V) r = tgt;
            else                       r = cur - STEP_V;
        end
        return r;
    endfunction

    assign wr_ok   = wr_en && (int'(wr_addr) < NUM_LEDS);
    assign rd_ok   = (int'(address) < NUM_LEDS);
    assign wr_idx  = wr_addr[IW-1:0];
    assign rd_idx  = address[IW-1:0];
    assign wr_data = {wr_red, wr_green, wr_blue};

    assign tick = (cnt_q == TICK_CNT);

    // The step always reads the pre-write target; a same-cycle write only
    // lands at the edge.
    assign step_en   = (state_q == WALK);
    assign last_walk = step_en && (index_q == LAST_IDX);
    assign cur_sel   = cur_mem[index_q];
    assign tgt_sel   = tgt_mem[index_q];
    assign step_val  = {step_ch(cur_sel[23:16], tgt_sel[23:16]),
                        step_ch(cur_sel[15:8],  tgt_sel[15:8]),
                        step_ch(cur_sel[7:0],   tgt_sel[7:0])};
    assign step_diff = step_en && (step_val != tgt_sel);

    assign busy = (state_q == WALK);

    // Free-running fade tick divider
    always_ff @(posedge clk) begin
        if (reset)         cnt_q <= '0;
        else if (tick)     cnt_q <= '0;
        else               cnt_q <= cnt_q + CW'(1);
    end

    // Walk FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    // Walk FSM: next state. Ticks seen while walking are simply ignored.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        case (state_q)
            IDLE: begin
                index_d = '0;
                if (tick) state_d = WALK;
            end
            WALK: begin
                if (index_q == LAST_IDX) begin
                    state_d = IDLE;
                    index_d = '0;
                end else begin
                    index_d = index_q + IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                index_d = '0;
            end
        endcase
    end

    // Entry storage. The write is placed after the step so a snap write to
    // the entry being stepped wins; a plain write leaves the step result.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                tgt_mem[i] <= '0;
                cur_mem[i] <= '0;
            end
        end else begin
            if (step_en) cur_mem[index_q] <= step_val;
            if (wr_ok) begin
                tgt_mem[wr_idx] <= wr_data;
                if (wr_snap) cur_mem[wr_idx] <= wr_data;
            end
        end
    end

    // Read port: samples the pre-update entry, so same-cycle changes
    // show up one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            {red_out, green_out, blue_out} <= '0;
        end else if (rd_ok) begin
            {red_out, green_out, blue_out} <= cur_mem[rd_idx];
        end else begin
            {red_out, green_out, blue_out} <= '0;
        end
    end

    // Settled tracking: differs accumulates over one walk and is cleared
    // while idle, so each walk judges the array afresh.
    always_ff @(posedge clk) begin
        if (reset) begin
            differs_q <= 1'b0;
            settled   <= 1'b1;
        end else begin
            if (step_en) differs_q <= differs_q | step_diff | wr_ok;
            else         differs_q <= 1'b0;

            if (last_walk)  settled <= !(differs_q | step_diff | wr_ok);
            else if (wr_ok) settled <= 1'b0;
        end
    end

endmodule
